// File: rtl/video_timing_gen.sv
// Raster timing generator: a locked-PLL gate feeds h/v counters whose decode is
// registered into aligned sync, data-enable, coordinate and strobe outputs.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  logic        lock_meta;
  logic        lock_s;
  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  // Stage 0: two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Stage 1: run/wait state and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (lock_s) state <= RUN;
        end
        RUN: begin
          if (!lock_s) begin
            // Abandon the frame; re-lock restarts at the origin
            state <= WAIT_LOCK;
            h_cnt <= '0;
            v_cnt <= '0;
          end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  // Stage 2: registered decode, every output derived from the same counter pair
  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hsync       <= ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? HS_POL : ~HS_POL;
      vsync       <= ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? VS_POL : ~VS_POL;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == 12'd0);
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default 720p instance and a small negative-polarity raster
// share clock, reset and lock; each task drives a scenario and checks inline.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic        a_de, a_hs, a_vs, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic        b_de, b_hs, b_vs, b_ls, b_fs;
  logic [11:0] b_x, b_y;

  video_timing_gen dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .de(a_de), .hsync(a_hs), .vsync(a_vs), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .de(b_de), .hsync(b_hs), .vsync(b_vs), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // {de, hsync, vsync, x, y, line_start, frame_start}
  wire [28:0] obs_a = {a_de, a_hs, a_vs, a_x, a_y, a_ls, a_fs};
  wire [28:0] obs_b = {b_de, b_hs, b_vs, b_x, b_y, b_ls, b_fs};

  localparam logic [28:0] IDLE_A  = {1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
  localparam logic [28:0] IDLE_B  = {1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0};
  localparam logic [28:0] START_A = {1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1};
  localparam logic [28:0] START_B = {1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b1, 1'b1};

  task automatic step;
    @(negedge clk);
  endtask

  // Reset with lock held, release, and stop on the edge that shows (0,0)
  task automatic restart;
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (3) step;
    rst = 1'b0;
    repeat (4) step;
  endtask

  task automatic test_reset;
    int lat;
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (10) step;
    n_cmp++;
    if (obs_a !== IDLE_A) begin n_bad++; $display("FAIL reset_idle_a: got %h want %h", obs_a, IDLE_A); end
    n_cmp++;
    if (obs_b !== IDLE_B) begin n_bad++; $display("FAIL reset_idle_b: got %h want %h", obs_b, IDLE_B); end
    rst = 1'b0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      step;
      if (a_fs === 1'b1) begin lat = i; break; end
    end
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL lockup_latency: got %0d want 3", lat); end
    n_cmp++;
    if (obs_a !== START_A) begin n_bad++; $display("FAIL lockup_start_a: got %h want %h", obs_a, START_A); end
    n_cmp++;
    if (obs_b !== START_B) begin n_bad++; $display("FAIL lockup_start_b: got %h want %h", obs_b, START_B); end
  endtask

  // Starts on the (0,0) cycle of the default raster and scans line 0
  task automatic test_line_timing;
    int de_cnt, de_first, de_last, hs_cnt, hs_first, hs_last, ls_cnt, vs_cnt, pos_bad;
    de_cnt = 0; de_first = -1; de_last = -1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; vs_cnt = 0; pos_bad = 0;
    for (int i = 0; i < 1650; i++) begin
      if (a_de) begin de_cnt++; if (de_first < 0) de_first = i; de_last = i; end
      if (a_hs) begin hs_cnt++; if (hs_first < 0) hs_first = i; hs_last = i; end
      if (a_ls) ls_cnt++;
      if (a_vs) vs_cnt++;
      if (int'(a_x) != i || a_y != 12'd0) pos_bad++;
      step;
    end
    n_cmp++;
    if (de_cnt != 1280) begin n_bad++; $display("FAIL line_de_count: got %0d want 1280", de_cnt); end
    n_cmp++;
    if (de_first != 0 || de_last != 1279) begin n_bad++; $display("FAIL line_de_span: got %0d..%0d want 0..1279", de_first, de_last); end
    n_cmp++;
    if (hs_cnt != 40) begin n_bad++; $display("FAIL line_hs_count: got %0d want 40", hs_cnt); end
    n_cmp++;
    if (hs_first != 1390 || hs_last != 1429) begin n_bad++; $display("FAIL line_hs_span: got %0d..%0d want 1390..1429", hs_first, hs_last); end
    n_cmp++;
    if (ls_cnt != 1) begin n_bad++; $display("FAIL line_ls_count: got %0d want 1", ls_cnt); end
    n_cmp++;
    if (vs_cnt != 0) begin n_bad++; $display("FAIL line_vs_line0: got %0d want 0", vs_cnt); end
    n_cmp++;
    if (pos_bad != 0) begin n_bad++; $display("FAIL line_x_track: got %0d bad cycles want 0", pos_bad); end
    n_cmp++;
    if ({a_de, a_x, a_y, a_ls, a_fs} !== {1'b1, 12'd0, 12'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL line_wrap: got de=%b x=%0d y=%0d ls=%b fs=%b want de=1 x=0 y=1 ls=1 fs=0", a_de, a_x, a_y, a_ls, a_fs);
    end
  endtask

  // Small raster: 14 clocks per line, 7 lines per frame, both syncs active-low
  task automatic test_small_frame;
    int hs_low, hs_bad, vs_low, vs_bad, vs_edge_bad, vs_first, de_cnt, de_bad;
    int ls_n, ls_bad, last_ls, fs_n, wrap_bad, px, py;
    int fs_t[4];
    logic pvs;
    hs_low = 0; hs_bad = 0; vs_low = 0; vs_bad = 0; vs_edge_bad = 0; vs_first = -1;
    de_cnt = 0; de_bad = 0; ls_n = 0; ls_bad = 0; last_ls = -1; fs_n = 0; wrap_bad = 0;
    px = 0; py = 0; pvs = 1'b1;
    for (int k = 0; k < 4; k++) fs_t[k] = 0;
    restart;
    for (int i = 0; i <= 196; i++) begin
      if (!b_hs) begin hs_low++; if (b_x < 12'd10 || b_x > 12'd11) hs_bad++; end
      if (!b_vs) begin vs_low++; if (vs_first < 0) vs_first = i; if (b_y != 12'd5) vs_bad++; end
      if (i > 0 && b_vs != pvs && b_x != 12'd0) vs_edge_bad++;
      if (b_de) de_cnt++;
      if (b_de !== (b_x < 12'd8 && b_y < 12'd4)) de_bad++;
      if (b_ls) begin
        ls_n++;
        if ((last_ls >= 0 && i - last_ls != 14) || b_x != 12'd0) ls_bad++;
        last_ls = i;
      end
      if (b_fs) begin if (fs_n < 4) fs_t[fs_n] = i; fs_n++; end
      if (i > 0) begin
        if (int'(b_x) != ((px == 13) ? 0 : px + 1)) wrap_bad++;
        if (int'(b_y) != ((px == 13) ? ((py == 6) ? 0 : py + 1) : py)) wrap_bad++;
      end
      px = int'(b_x); py = int'(b_y); pvs = b_vs;
      step;
    end
    n_cmp++;
    if (hs_low != 28 || hs_bad != 0) begin n_bad++; $display("FAIL small_hsync: got low=%0d bad=%0d want low=28 bad=0", hs_low, hs_bad); end
    n_cmp++;
    if (vs_low != 28 || vs_bad != 0) begin n_bad++; $display("FAIL small_vsync: got low=%0d bad=%0d want low=28 bad=0", vs_low, vs_bad); end
    n_cmp++;
    if (vs_first != 70) begin n_bad++; $display("FAIL small_vsync_start: got %0d want 70", vs_first); end
    n_cmp++;
    if (vs_edge_bad != 0) begin n_bad++; $display("FAIL small_vsync_align: got %0d want 0", vs_edge_bad); end
    n_cmp++;
    if (de_cnt != 65 || de_bad != 0) begin n_bad++; $display("FAIL small_de: got cnt=%0d bad=%0d want cnt=65 bad=0", de_cnt, de_bad); end
    n_cmp++;
    if (ls_n != 15 || ls_bad != 0) begin n_bad++; $display("FAIL small_line_start: got n=%0d bad=%0d want n=15 bad=0", ls_n, ls_bad); end
    n_cmp++;
    if (fs_n != 3) begin n_bad++; $display("FAIL small_fs_count: got %0d want 3", fs_n); end
    n_cmp++;
    if (fs_t[1] - fs_t[0] != 98 || fs_t[2] - fs_t[1] != 98) begin
      n_bad++;
      $display("FAIL small_fs_period: got %0d,%0d want 98,98", fs_t[1] - fs_t[0], fs_t[2] - fs_t[1]);
    end
    n_cmp++;
    if (wrap_bad != 0) begin n_bad++; $display("FAIL small_wrap: got %0d bad steps want 0", wrap_bad); end
  endtask

  task automatic test_lock_loss;
    int idle_bad, early_bad;
    idle_bad = 0; early_bad = 0;
    restart;
    repeat (42) step;
    n_cmp++;
    if ({b_x, b_y} !== {12'd0, 12'd3}) begin n_bad++; $display("FAIL loss_pos: got x=%0d y=%0d want x=0 y=3", b_x, b_y); end
    pll_locked = 1'b0;
    repeat (3) step;
    n_cmp++;
    if ({b_de, b_x, b_y} !== {1'b1, 12'd3, 12'd3}) begin
      n_bad++;
      $display("FAIL loss_still_run: got de=%b x=%0d y=%0d want de=1 x=3 y=3", b_de, b_x, b_y);
    end
    step;
    n_cmp++;
    if (obs_b !== IDLE_B) begin n_bad++; $display("FAIL loss_idle_b: got %h want %h", obs_b, IDLE_B); end
    n_cmp++;
    if (obs_a !== IDLE_A) begin n_bad++; $display("FAIL loss_idle_a: got %h want %h", obs_a, IDLE_A); end
    for (int i = 0; i < 20; i++) begin
      step;
      if (obs_b !== IDLE_B || obs_a !== IDLE_A) idle_bad++;
    end
    n_cmp++;
    if (idle_bad != 0) begin n_bad++; $display("FAIL loss_stay_idle: got %0d busy cycles want 0", idle_bad); end
    pll_locked = 1'b1;
    repeat (3) begin
      step;
      if (obs_b !== IDLE_B || obs_a !== IDLE_A) early_bad++;
    end
    n_cmp++;
    if (early_bad != 0) begin n_bad++; $display("FAIL relock_early: got %0d early cycles want 0", early_bad); end
    step;
    n_cmp++;
    if (obs_b !== START_B || obs_a !== START_A) begin
      n_bad++;
      $display("FAIL relock_start: got a=%h b=%h want a=%h b=%h", obs_a, obs_b, START_A, START_B);
    end
  endtask

  task automatic test_mid_reset;
    int early_bad;
    early_bad = 0;
    restart;
    repeat (2150) step;
    n_cmp++;
    if ({a_de, a_x, a_y} !== {1'b1, 12'd500, 12'd1}) begin
      n_bad++;
      $display("FAIL mrst_pos: got de=%b x=%0d y=%0d want de=1 x=500 y=1", a_de, a_x, a_y);
    end
    rst = 1'b1;
    step;
    n_cmp++;
    if (obs_a !== IDLE_A) begin n_bad++; $display("FAIL mrst_idle_a: got %h want %h", obs_a, IDLE_A); end
    n_cmp++;
    if (obs_b !== IDLE_B) begin n_bad++; $display("FAIL mrst_idle_b: got %h want %h", obs_b, IDLE_B); end
    rst = 1'b0;
    repeat (3) begin
      step;
      if (obs_a !== IDLE_A) early_bad++;
    end
    n_cmp++;
    if (early_bad != 0) begin n_bad++; $display("FAIL mrst_early: got %0d early cycles want 0", early_bad); end
    step;
    n_cmp++;
    if (obs_a !== START_A) begin n_bad++; $display("FAIL mrst_restart: got %h want %h", obs_a, START_A); end
  endtask

  initial begin
    test_reset;
    test_line_timing;
    test_small_frame;
    test_lock_loss;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
